ssd_display_scheduler: RTL
==========================

# ssd_display_scheduler

Time-shares the 8-digit seven-segment display between four 32-bit debug sources: core PC, selected register, UART status and a user word. Shows each valid source for a programmable dwell time in round-robin order. Supports manual advance and a pinned mode. Its `disp_word` output drives the `din` input of the 8-digit SSD wrapper, whose digit 0 shows bits [31:28].

## Interface
- `DWELL_CYCLES`, default 100_000_000: cycles each source stays on the display (1 s at 100 MHz); legal range 2..2^CNT_W-1.
- `CNT_W`, default 27: dwell counter width.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `src_valid`  in  4  per-source "has data to show" flags; bit i belongs to `src_data{i}`.
- `src_data0`..`src_data3`  in  32 each  source words.
- `next_pulse`  in  1  one-cycle manual advance request (debounced button).
- `pin_en`  in  1  level; freezes the display on `pin_sel`.
- `pin_sel`  in  2  source index shown while `pin_en`=1.
- `disp_word`  out  32  word for the SSD wrapper; registered.
- `disp_src`  out  2  index of the source currently shown; registered.
- `disp_valid`  out  1  1 when `disp_word` carries live source data.
- `src_ack`  out  4  one-cycle pulse on bit i when source i becomes the displayed source.

## Operation
- States:
  - IDLE: nothing shown.
  - SHOW: round-robin display.
  - PIN: forced display.
- Internal registers: `cur` (2 b), dwell counter `cnt` (CNT_W b).
- Round-robin search: from `cur` examine (cur+1), (cur+2), (cur+3), (cur+4) mod 4. Pick the first with `src_valid`=1. `cur` itself is examined last, so it is kept only if it is the sole valid source.
- IDLE:
  - `disp_valid`=0, `disp_word` holds 0.
  - If `pin_en`, go to PIN.
  - Else if any `src_valid`, run the search and go to SHOW with the result.
- SHOW:
  - Each cycle, `disp_word` <= `src_data[cur]` while `src_valid[cur]`=1.
  - If `src_valid[cur]` drops, `disp_word` holds its last value and `disp_valid` goes to 0. Dwell continues.
  - `cnt` increments each cycle. An advance event fires when `cnt`==DWELL_CYCLES-1 or `next_pulse`=1. Both in the same cycle count as one advance.
  - On advance: search.
    - Hit: load `cur`, clear `cnt`, pulse `src_ack`. This happens even when the hit equals the old `cur`.
    - No hit: go to IDLE, `disp_word` <= 0, `cnt` <= 0.
- PIN (entered from any state when `pin_en`=1):
  - `cur` <= `pin_sel` every cycle.
  - `disp_word` <= `src_data[pin_sel]` unconditionally.
  - `disp_valid` <= `src_valid[pin_sel]`.
  - `cnt` held at 0; `next_pulse` ignored.
  - `src_ack` pulses on PIN entry and on every change of `pin_sel`.
- Leaving PIN (`pin_en` falls):
  - If `src_valid[cur]`, go to SHOW with `cnt`=0.
  - Else run the search: go to SHOW on a hit, IDLE otherwise.
- `disp_src` always equals `cur`, registered with `disp_word`.
- `pin_en` has priority over every other input; `rst` has priority over everything.

## Timing
- Reset values: state IDLE, `cur`=3 (so the first search starts at source 0), `cnt`=0, `disp_word`=0, `disp_src`=3, `disp_valid`=0, `src_ack`=0.
- Latency:
  - Input change to `disp_word` update: 1 cycle (all outputs registered).
  - IDLE: `src_valid` rising in cycle N gives SHOW with `disp_word`/`disp_valid`/`src_ack` in cycle N+1.
- Dwell: a source entered in cycle N (`cnt`=0) is replaced in cycle N+DWELL_CYCLES. Exactly DWELL_CYCLES cycles on display when no `next_pulse` occurs.
- `next_pulse` in cycle M: new source visible in cycle M+1.
- `src_ack` is high for exactly one cycle per display switch, coincident with the new `disp_src`.
- `rst` asserted mid-dwell or in PIN: all outputs return to reset values on the next edge. The `src_ack` pulse in flight is cancelled.
- `cnt` never exceeds DWELL_CYCLES-1; no wrap-around.

## Test plan
- Reset, then `src_valid`=4'b0101, DWELL_CYCLES=4, data0=32'h1111_1111, data2=32'h2222_2222 -> `src_ack[0]` 1 cycle after valid. Display alternates 0,2,0,2 every 4 cycles, `src_ack` pulsing on each switch.
- `src_valid`=4'b1000 only -> source 3 redisplayed every 4 cycles with `src_ack[3]` pulse. Drop valid mid-dwell -> `disp_valid`=0 next cycle, word held. At dwell end, IDLE with `disp_word`=0.
- `next_pulse` and dwell expiry in the same cycle, `src_valid`=4'b1111, `cur`=1 -> single advance to source 2, not 3.
- `pin_en`=1, `pin_sel`=2, `src_valid[2]`=0, data2=32'hDEAD_BEEF -> `disp_word`=32'hDEAD_BEEF, `disp_valid`=0, `next_pulse` ignored. Change `pin_sel` to 1 -> `src_ack[1]` pulse. Release `pin_en` with `src_valid[1]`=1 -> SHOW on 1 with `cnt`=0.
- `rst` asserted mid-dwell in SHOW and again in PIN -> next edge: `disp_word`=0, `disp_src`=3, `disp_valid`=0, no `src_ack`. After release, the first valid source is 0 when `src_valid[0]`=1.

Source files
------------

// File: rtl/ssd_display_scheduler_if.sv
// Bundle of source words, user controls and display outputs shared between the
// debug sources and the seven-segment display scheduler.
interface ssd_display_scheduler_if;
  logic [3:0]  src_valid;
  logic [31:0] src_data0;
  logic [31:0] src_data1;
  logic [31:0] src_data2;
  logic [31:0] src_data3;
  logic        next_pulse;
  logic        pin_en;
  logic [1:0]  pin_sel;
  logic [31:0] disp_word;
  logic [1:0]  disp_src;
  logic        disp_valid;
  logic [3:0]  src_ack;

  modport master (
    output src_valid, src_data0, src_data1, src_data2, src_data3,
    output next_pulse, pin_en, pin_sel,
    input  disp_word, disp_src, disp_valid, src_ack
  );

  modport slave (
    input  src_valid, src_data0, src_data1, src_data2, src_data3,
    input  next_pulse, pin_en, pin_sel,
    output disp_word, disp_src, disp_valid, src_ack
  );
endinterface

// File: rtl/ssd_display_scheduler.sv
// Round-robin time-sharing of an 8-digit seven-segment display between four
// 32-bit debug sources, with dwell timer, manual advance and pinned mode.
module ssd_display_scheduler #(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input logic                    clk,
  input logic                    rst,
  ssd_display_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, PIN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic             valid_q, valid_d;
  logic [3:0]       ack_q, ack_d;

  logic [31:0] data [4];
  assign data[0] = bus.src_data0;
  assign data[1] = bus.src_data1;
  assign data[2] = bus.src_data2;
  assign data[3] = bus.src_data3;

  // Search from cur+1 upward; iterating downward lets the nearest candidate win,
  // and k=4 wraps onto cur itself so it is only chosen when nothing else is valid.
  logic       hit;
  logic [1:0] hit_idx;
  always_comb begin
    logic [1:0] cand;
    hit     = 1'b0;
    hit_idx = cur_q;
    cand    = cur_q;
    for (int k = 4; k >= 1; k--) begin
      cand = cur_q + 2'(k);
      if (bus.src_valid[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  logic advance;
  assign advance = (cnt_q == LAST) || bus.next_pulse;

  logic load;
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    ack_d   = '0;
    load    = 1'b0;

    if (bus.pin_en) begin
      state_d = PIN;
      cur_d   = bus.pin_sel;
      cnt_d   = '0;
      word_d  = data[bus.pin_sel];
      valid_d = bus.src_valid[bus.pin_sel];
      if (state_q != PIN || bus.pin_sel != cur_q) ack_d = 4'b0001 << bus.pin_sel;
    end else begin
      unique case (state_q)
        IDLE: load = hit;
        SHOW: begin
          if (advance) begin
            load = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (bus.src_valid[cur_q]) begin
              word_d  = data[cur_q];
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        PIN: begin
          if (bus.src_valid[cur_q]) begin
            state_d = SHOW;
            cnt_d   = '0;
            word_d  = data[cur_q];
            valid_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // A requested switch either lands on the search result or falls back to idle.
      if (load) begin
        cnt_d = '0;
        if (hit) begin
          state_d = SHOW;
          cur_d   = hit_idx;
          word_d  = data[hit_idx];
          valid_d = 1'b1;
          ack_d   = 4'b0001 << hit_idx;
        end else begin
          state_d = IDLE;
          word_d  = '0;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= 2'd3;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.disp_word  = word_q;
  assign bus.disp_src   = cur_q;
  assign bus.disp_valid = valid_q;
  assign bus.src_ack    = ack_q;
endmodule
